// File: rtl/calc_seq.sv
// calc_seq: calculator sequencer.
// Synchronises and debounces the execute button, latches the opcode and the
// operands once per accepted press, waits out the ALU latency and writes the
// low 16 bits of the ALU result back into the accumulator.
//
// ALU interface: alu_op/op1/op2 are loaded in LATCH and then held steady;
// alu_result/alu_zero are sampled once, at the end of WRITE, after ALU_LAT
// EXEC cycles. done is high for exactly that WRITE cycle.
module calc_seq #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ALU_LAT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnd,
    input  logic [3:0]  alu_op_in,
    input  logic [15:0] sw,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic [15:0] accum,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATCH   = 3'd1,
        EXEC    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] LAT_LAST  = 16'(ALU_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_btn_s;
    logic        w_latch;
    logic        w_write;
    logic [3:0]  r_alu_op;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [15:0] r_accum;
    logic        r_zero;
    logic        w_unused;

    assign w_btn_s  = r_sync2;
    // Upper result bits are deliberately dropped: the accumulator wraps.
    assign w_unused = ^alu_result[31:16];

    // Next-state, shared counter and load strobes for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cnt == DEB_LIMIT) begin
                    w_state_nxt = LATCH;
                    w_cnt_nxt   = 16'd0;
                end else if (w_btn_s) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
            LATCH: begin
                w_latch     = 1'b1;
                w_cnt_nxt   = 16'd0;
                w_state_nxt = EXEC;
            end
            EXEC: begin
                if (r_cnt == LAT_LAST) begin
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = WRITE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            WRITE: begin
                w_write     = 1'b1;
                w_cnt_nxt   = 16'd0;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (r_cnt == DEB_LIMIT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 16'd0;
                end else if (!w_btn_s) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end else begin
                    w_cnt_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // State, counter, synchroniser and datapath registers; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 16'd0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_alu_op <= 4'd0;
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
            r_accum  <= 16'd0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sync1 <= btnd;
            r_sync2 <= r_sync1;
            if (w_latch) begin
                r_alu_op <= alu_op_in;
                r_op1    <= {{16{r_accum[15]}}, r_accum};
                r_op2    <= {{16{sw[15]}}, sw};
            end
            if (w_write) begin
                r_accum <= alu_result[15:0];
                r_zero  <= alu_zero;
            end
        end
    end

    assign alu_op    = r_alu_op;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign accum     = r_accum;
    assign zero      = r_zero;
    assign busy      = (r_state == LATCH) || (r_state == EXEC) || (r_state == WRITE);
    assign done      = (r_state == WRITE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: randomized bench for calc_seq with a behavioural ALU and an
// operation-level accumulator model (one expected result per press).
module tb_calc_seq;

  logic        clk;
  logic        rst;
  logic        btnd;
  logic [3:0]  alu_op_in;
  logic [15:0] sw;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [15:0] accum;
  logic        zero;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_accum;
  logic [15:0] exp_q[$];

  calc_seq #(.DEBOUNCE_CYCLES(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .btnd(btnd), .alu_op_in(alu_op_in), .sw(sw),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_op(alu_op),
    .op1(op1), .op2(op2), .accum(accum), .zero(zero), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: 0 and, 1 or, 2 add, 6 sub, others give 0
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] v);
    return 32'($signed(v));
  endfunction

  always_comb begin
    alu_result = alu_model(alu_op, op1, op2);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one full press: hold btnd for 'hold' cycles, then release and settle
  task automatic do_op(input logic [15:0] s, input logic [3:0] op, input int hold, input bit change_mid);
    logic [31:0] res;
    logic [15:0] exp_acc;
    logic [31:0] exp_op1;
    int got_lat;
    int extra;
    exp_op1 = sext(model_accum);
    res     = alu_model(op, exp_op1, sext(s));
    exp_q.push_back(res[15:0]);
    got_lat = 0;
    extra   = 0;
    @(negedge clk);
    sw        = s;
    alu_op_in = op;
    btnd      = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (change_mid && i == 8) begin
        sw        = 16'($urandom);
        alu_op_in = 4'($urandom_range(0, 15));
      end
      if (done) begin
        if (got_lat == 0) begin
          got_lat = i;
          chk("op1", op1, exp_op1);
          chk("op2", op2, sext(s));
          chk("alu_op", {28'd0, alu_op}, {28'd0, op});
          chk("busy_write", {31'd0, busy}, 32'd1);
        end else begin
          extra++;
        end
      end
      if (got_lat != 0 && i == got_lat + 1) begin
        exp_acc = exp_q.pop_front();
        chk("accum", {16'd0, accum}, {16'd0, exp_acc});
        chk("zero", {31'd0, zero}, {31'd0, (res == 32'd0)});
        chk("done_pulse", {31'd0, done}, 32'd0);
      end
    end
    chk("latency", got_lat, 9);
    btnd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("single_op", extra, 0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("ops_hold", op2, sext(s));
    model_accum = res[15:0];
    exp_q.delete();
  endtask

  task automatic do_glitch();
    int saw_busy;
    saw_busy = 0;
    @(negedge clk);
    btnd = 1'b1;
    repeat (3) @(negedge clk);
    btnd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) saw_busy++;
    end
    chk("glitch_busy", saw_busy, 0);
    chk("glitch_accum", {16'd0, accum}, {16'd0, model_accum});
  endtask

  task automatic do_reset_in_exec(input logic [15:0] s);
    int dones;
    dones = 0;
    @(negedge clk);
    sw        = s;
    alu_op_in = 4'd2;
    btnd      = 1'b1;
    repeat (8) @(negedge clk);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_no_done", {31'd0, done}, 32'd0);
    rst  = 1'b1;
    btnd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec_state", {29'd0, dbg_state}, 32'd0);
    chk("rst_exec_accum", {16'd0, accum}, 32'd0);
    chk("rst_exec_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst_exec_nowrite", dones, 0);
    model_accum = 16'd0;
  endtask

  // main driver
  initial begin
    logic [3:0] ops[4];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6;
    rst = 1'b1; btnd = 1'b0; sw = 16'd0; alu_op_in = 4'd0;
    model_accum = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_accum", {16'd0, accum}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h0005, 4'd2, 20, 1'b0);
    do_glitch();
    do_op(16'hFFFB, 4'd2, 20, 1'b0);
    do_op(16'h1234, 4'd2, 12, 1'b0);
    do_reset_in_exec(16'h0777);
    do_op(16'h0042, 4'd2, 12, 1'b0);
    do_op(16'h0101, 4'd6, 14, 1'b1);
    for (int k = 0; k < 8; k++) begin
      do_op(16'($urandom), ops[$urandom_range(0, 3)], $urandom_range(11, 20), k[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
Name: calc_seq

Overview:
- Sequencer for the calculator datapath.
- Takes a raw execute button, synchronises and debounces it, and latches the 4-bit ALU opcode produced by the button encoder.
- Drives the ALU operands from a 16-bit accumulator and the switches, waits out the ALU latency, then writes the result back into the accumulator.
- Sits between the board I/O, the button encoder and the shared ALU.
- Issues exactly one ALU operation per debounced press.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-stable cycles needed to accept a press or a release; legal range 1..65535.
- ALU_LAT, 1: cycles the ALU result needs after its inputs are stable; legal range 1..15.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- btnd, input, 1: raw execute button, asynchronous to clk.
- alu_op_in, input, 4: opcode from the button encoder; sampled only in LATCH.
- sw, input, 16: signed second operand, raw.
- alu_result, input, 32: ALU result.
- alu_zero, input, 1: ALU zero flag.
- alu_op, output, 4: registered opcode driven to the ALU.
- op1, output, 32: sign-extended accumulator, driven to the ALU.
- op2, output, 32: sign-extended sw, driven to the ALU.
- accum, output, 16: accumulator, for the LEDs.
- zero, output, 1: registered alu_zero from the last write.
- busy, output, 1: high in LATCH, EXEC and WRITE.
- done, output, 1: one-cycle pulse in WRITE.

Behaviour:
- Reset (rst high at a rising edge):
  - All outputs go to 0, FSM goes to IDLE, counters clear, sync flops clear.
  - Reset overrides everything, including an operation in progress; no write-back occurs.
- Synchroniser: btnd passes through 2 flops to give btn_s. btn_s lags btnd by 2 cycles.
- FSM states: IDLE, LATCH, EXEC, WRITE, RELEASE.
- IDLE:
  - cnt increments while btn_s=1 and clears to 0 when btn_s=0.
  - When cnt reaches DEBOUNCE_CYCLES, go to LATCH and clear cnt.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- LATCH (1 cycle):
  - alu_op <= alu_op_in.
  - op1 <= {16{accum[15]}, accum}.
  - op2 <= {16{sw[15]}, sw}.
  - Go to EXEC.
- EXEC:
  - alu_op, op1 and op2 hold.
  - Counter runs for ALU_LAT cycles, then go to WRITE.
- WRITE (1 cycle):
  - accum <= alu_result[15:0]; upper bits are discarded with no saturation.
  - zero <= alu_zero.
  - done=1.
  - Go to RELEASE.
- RELEASE:
  - cnt increments while btn_s=0 and clears when btn_s=1.
  - At DEBOUNCE_CYCLES, go to IDLE.
  - Holding the button yields exactly one operation.
- Latency: first cycle btn_s=1 to done pulse = DEBOUNCE_CYCLES + 1 (LATCH) + ALU_LAT + 1 cycles.
- Register stability:
  - alu_op, op1 and op2 change only in LATCH and keep their values after the op.
  - accum changes only in WRITE or on reset.
- Input sampling:
  - sw and alu_op_in changes outside LATCH are ignored.
  - btnd changes during LATCH, EXEC or WRITE are ignored.
- Counters: cnt is 16 bits and never wraps, because it is compared and cleared at DEBOUNCE_CYCLES.

Test Plan:
- Defaults apply; the bench ALU model is combinational add when alu_op=4'b0010. Hold rst 2 cycles:
  - accum=0, zero=0, busy=0, done=0, alu_op=0, op1=0, op2=0.
- sw=16'h0005, alu_op_in=4'b0010, btnd high for 20 cycles:
  - op1=0, op2=32'h00000005.
  - done pulses once, 7 cycles after btn_s rises; accum=16'h0005.
  - No second done before release plus 4 stable-low cycles.
- Glitch: btnd high for 3 cycles, then low:
  - no LATCH, busy stays 0, accum unchanged.
- sw=16'hFFFB (-5), add op, accum=5:
  - op2=32'hFFFFFFFB.
  - accum=16'h0000, zero=1 (bench drives alu_zero=1 for a zero result).
- Assert rst in the EXEC cycle:
  - next cycle state is IDLE, accum=0, no done pulse.
  - A subsequent press operates normally.
- Change sw and alu_op_in during EXEC:
  - op2 and alu_op keep their LATCH-time values.
  - Result reflects the latched values only.
